// File: rtl/pipe_pkg.sv
// Shared Y86-style pipeline constants: icodes, status codes, register IDs and
// the control FSM state encoding.
package pipe_pkg;

  localparam logic [3:0] I_NOP    = 4'h0;
  localparam logic [3:0] I_HALT   = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_RET_E  = 2'd1,
    ST_RET_M  = 2'd2,
    ST_HALTED = 2'd3
  } pipe_state_e;

  // A writeback status that stops the machine for good (until reset).
  function automatic logic is_fatal_stat(input logic [2:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall / bubble performance counters; both wrap naturally at 2^32.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        bubble_inc,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall_inc) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (bubble_inc) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control: load-use, mispredict, ret handling and halt.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        set_cc,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  pipe_state_e state_q, state_d;
  logic        halted_q, halted_d;
  logic        load_use, mispredict, ret_start, ret_busy, bad_stat;

  always_comb begin
    load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                 (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispredict = (E_icode == I_JXX) && !e_Cnd;
    // A ret only enters the bubble sequence when nothing older blocks it.
    ret_start  = (state_q == ST_RUN) && (D_icode == I_RET) && !load_use && !mispredict;
    ret_busy   = ret_start || (state_q == ST_RET_E) || (state_q == ST_RET_M);
    bad_stat   = (m_stat != S_AOK) || (W_stat != S_AOK);

    case (state_q)
      ST_RUN:    state_d = ret_start ? ST_RET_E : ST_RUN;
      ST_RET_E:  state_d = ST_RET_M;
      ST_RET_M:  state_d = ST_RUN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    if (is_fatal_stat(W_stat)) begin
      state_d = ST_HALTED;
    end else begin
      state_d = state_d;
    end
    halted_d = (state_d == ST_HALTED);

    if (state_q == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
    end else begin
      F_stall  = load_use || ret_busy;
      D_stall  = load_use;
      // Stall wins over bubble in decode.
      D_bubble = (mispredict || ret_busy) && !load_use;
      E_bubble = load_use || mispredict;
      M_bubble = bad_stat;
      W_stall  = (W_stat != S_AOK);
      set_cc   = (E_icode == I_OPQ) && !bad_stat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_inc, bubble_inc;

  assign stall_inc  = F_stall && (state_q != ST_HALTED);
  assign bubble_inc = (D_bubble || E_bubble) && (state_q != ST_HALTED);

  pipe_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .stall_inc  (stall_inc),
    .bubble_inc (bubble_inc),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`else
  assign stall_cnt  = 32'd0;
  assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a behavioural model (ret tracked as a remaining-cycle count).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [31:0] stall_cnt, bubble_cnt;

  int          n_checks = 0;
  int          n_errors = 0;

  bit          m_halted;
  int          m_ret_left;
  int unsigned m_stall, m_bubble;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef PIPE_CTRL_PERF_EN
    return m_stall;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_bubble();
`ifdef PIPE_CTRL_PERF_EN
    return m_bubble;
`else
    return 32'd0;
`endif
  endfunction

  // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}.
  function automatic logic [6:0] model_ctrl(output bit ret_new);
    bit lu, mp, busy, bad;
    ret_new = 1'b0;
    if (m_halted) return 7'b1101110;
    lu   = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'd15 &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
    mp   = (E_icode == 4'd7) && (e_Cnd == 1'b0);
    ret_new = (m_ret_left == 0) && (D_icode == 4'd9) && !lu && !mp;
    busy = ret_new || (m_ret_left > 0);
    bad  = (m_stat != 3'd1) || (W_stat != 3'd1);
    return {lu || busy, lu, (mp || busy) && !lu, lu || mp, bad,
            W_stat != 3'd1, (E_icode == 4'd6) && !bad};
  endfunction

  function automatic logic [6:0] dut_ctrl();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  task automatic set_idle();
    D_icode = 4'd0; d_srcA = 4'd15; d_srcB = 4'd15;
    E_icode = 4'd0; E_dstM = 4'd15; e_Cnd = 1'b1;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  // Called at a negedge after inputs are set; returns at the next negedge.
  task automatic step(input string tag, input int want);
    logic [6:0] e;
    bit         rn;
    #1;
    e = model_ctrl(rn);
    check_eq({tag, " ctrl"}, {25'd0, dut_ctrl()}, {25'd0, e});
    if (want >= 0) check_eq({tag, " ctrl_const"}, {25'd0, dut_ctrl()}, want[31:0]);
    if (!m_halted) begin
      m_stall  += e[6] ? 1 : 0;
      m_bubble += (e[4] || e[3]) ? 1 : 0;
    end
    if (W_stat >= 3'd2 && W_stat <= 3'd4) m_halted = 1'b1;
    else if (m_halted) m_halted = 1'b1;
    else if (m_ret_left > 0) m_ret_left--;
    else if (rn) m_ret_left = 2;
    @(posedge clk);
    #1;
    check_eq({tag, " halted"}, {31'd0, halted}, {31'd0, m_halted});
    check_eq({tag, " stall_cnt"}, stall_cnt, exp_stall());
    check_eq({tag, " bubble_cnt"}, bubble_cnt, exp_bubble());
    @(negedge clk);
  endtask

  // Async reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_halted = 1'b0; m_ret_left = 0; m_stall = 0; m_bubble = 0;
    check_eq("rst halted", {31'd0, halted}, 32'd0);
    check_eq("rst stall_cnt", stall_cnt, 32'd0);
    check_eq("rst bubble_cnt", bubble_cnt, 32'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e_tab [8];
    e_tab = '{4'd5, 4'd11, 4'd7, 4'd6, 4'd9, 4'd0, 4'd2, 4'd5};
    set_idle();
    @(negedge clk);
    do_reset();
    step("idle", 7'b0000000);

    // Load-use, then the same with no memory destination.
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    step("load_use", 7'b1101000);
    E_dstM = 4'd15;
    step("no_dst", 7'b0000000);
    set_idle();

    // Ret: three cycles of F_stall + D_bubble, then quiet.
    D_icode = 4'd9;
    step("ret0", 7'b1010000);
    D_icode = 4'd0;
    step("ret1", 7'b1010000);
    step("ret2", 7'b1010000);
    step("ret_done", 7'b0000000);

    // Mispredict squashes a ret in decode.
    E_icode = 4'd7; e_Cnd = 1'b0; D_icode = 4'd9;
    step("mispredict_ret", 7'b0011000);
    set_idle();
    step("after_mp", 7'b0000000);

    // Load-use holds a ret, which then starts the following cycle.
    E_icode = 4'd11; E_dstM = 4'd2; d_srcB = 4'd2; D_icode = 4'd9;
    step("lu_ret", 7'b1101000);
    E_icode = 4'd0; E_dstM = 4'd15;
    step("ret_after_lu", 7'b1010000);
    D_icode = 4'd0;
    step("ret_after_lu1", -1);
    step("ret_after_lu2", -1);
    step("ret_after_lu3", 7'b0000000);

    // Fatal status during RET_E halts; halted blocks set_cc.
    do_reset();
    D_icode = 4'd9;
    step("h_ret", 7'b1010000);
    D_icode = 4'd0; W_stat = 3'd3;
    step("h_ret_e_adr", 7'b1010110);
    W_stat = 3'd1; E_icode = 4'd6;
    step("halted_opq", 7'b1101110);
    check_eq("halted_flag", {31'd0, halted}, 32'd1);
    do_reset();
    set_idle();
    step("post_rst", 7'b0000000);
    E_icode = 4'd6;
    step("opq", 7'b0000001);
    m_stat = 3'd3;
    step("opq_mbad", 7'b0000100);
    set_idle();

    // One ret plus one load-use for the counters.
    do_reset();
    D_icode = 4'd9;
    step("c_ret0", -1);
    D_icode = 4'd0;
    step("c_ret1", -1);
    step("c_ret2", -1);
    E_icode = 4'd5; E_dstM = 4'd1; d_srcA = 4'd1;
    step("c_lu", 7'b1101000);
    set_idle();
    step("c_idle", 7'b0000000);
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf stall_cnt", stall_cnt, 32'd4);
    check_eq("perf bubble_cnt", bubble_cnt, 32'd4);
`else
    check_eq("perf stall_cnt", stall_cnt, 32'd0);
    check_eq("perf bubble_cnt", bubble_cnt, 32'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0 || (m_halted && $urandom_range(0, 3) == 0)) do_reset();
      D_icode = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
      E_icode = e_tab[$urandom_range(0, 7)];
      E_dstM  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      d_srcA  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      d_srcB  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      W_stat  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
      step("rand", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on posedge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 D_icode  input  4  icode held in decode register.
REQ-004 d_srcA, d_srcB  input  4 each  decode-stage source register IDs (0xF = none).
REQ-005 E_icode, E_dstM  input  4 each  execute-register icode and memory destination.
REQ-006 e_Cnd  input  1  execute-stage branch condition.
REQ-007 m_stat, W_stat  input  3 each  memory-stage and writeback status.
REQ-008 F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc  output  1 each  pipeline register controls, combinational from inputs and state.
REQ-009 halted  output  1  registered; high once the machine has stopped.
REQ-010 stall_cnt, bubble_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-011 FSM states: RUN, RET_E, RET_M, HALTED; state is registered.
REQ-012 Load-use: E_icode in {MRMOVQ=5, POPQ=0xB}, E_dstM != 0xF, E_dstM equals d_srcA or d_srcB -> F_stall=1, D_stall=1, E_bubble=1.
REQ-013 Mispredict: E_icode=JXX(7) and e_Cnd=0 -> D_bubble=1, E_bubble=1.
REQ-014 Ret in D: state RUN, D_icode=RET(9), no load-use, no mispredict -> F_stall=1, D_bubble=1; next state RET_E.
REQ-015 RET_E -> F_stall=1, D_bubble=1; next RET_M. RET_M -> F_stall=1, D_bubble=1; next RUN (3 total cycles of F_stall+D_bubble).
REQ-016 Load-use with ret in D: load-use outputs only; D_bubble=0; FSM stays RUN; ret is re-evaluated next cycle.
REQ-017 Mispredict with ret in D: mispredict outputs only; ret squashed; FSM stays RUN.
REQ-018 m_stat != AOK(1) or W_stat != AOK -> M_bubble=1; W_stat != AOK -> W_stall=1.
REQ-019 set_cc = (E_icode=OPQ(6)) and m_stat=AOK and W_stat=AOK and state != HALTED.
REQ-020 W_stat in {HLT=2, ADR=3, INS=4} -> next state HALTED from any state, with priority over all other transitions.
REQ-021 HALTED: F_stall=D_stall=W_stall=E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1; exit only by reset.
REQ-022 In RUN with no hazard, all control outputs are 0.
REQ-023 D_stall and D_bubble are never both 1; when both would apply, stall wins.

Reset
REQ-024 rst=1 -> state RUN, halted=0, counters 0, immediately and independent of clk.
REQ-025 Reset during RET_E/RET_M or HALTED -> returns to RUN; no residual stall after release.

Configuration
REQ-026 PIPE_CTRL_PERF_EN defined -> stall_cnt increments on each clk where F_stall=1 and state != HALTED; bubble_cnt increments where D_bubble or E_bubble = 1 and state != HALTED; both wrap at 2^32.
REQ-027 PIPE_CTRL_PERF_EN undefined -> counter logic absent; stall_cnt and bubble_cnt tied to 0.

Structure
REQ-028 Shared package pipe_pkg holds icode constants (NOP, HALT, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ), stat codes (AOK/HLT/ADR/INS), RNONE=0xF, FSM state encoding.
REQ-029 Counters live in one sub-module pipe_perf_cnt, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-030 E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=D_stall=E_bubble=1, D_bubble=0; with E_dstM=0xF -> all 0.
REQ-031 D_icode=9 in RUN for one cycle, then 0 -> F_stall=D_bubble=1 for exactly 3 cycles, state RUN on 4th.
REQ-032 E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=E_bubble=1, F_stall=0, FSM stays RUN.
REQ-033 W_stat=3 during RET_E -> next cycle HALTED, halted=1, set_cc=0 with E_icode=6; rst pulse -> RUN, halted=0.
REQ-034 With PIPE_CTRL_PERF_EN, one ret plus one load-use -> stall_cnt=4, bubble_cnt=4; without macro -> both 0.
